// File: rtl/timed_seq_rec.sv
// timed_seq_rec: records every value change on a parallel data bus as a
// (value, duration-in-ticks) entry into a FIFO.
// The FIFO is drained through a first-word-fall-through read port.
module timed_seq_rec #(
  parameter int unsigned MAIN_HZ   = 1_000_000,
  parameter int unsigned TICK_HZ   = 1_000,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned TIME_BITS = 16,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_enable,
  input  logic [DATA_BITS-1:0]      in_data,
  input  logic                      in_read,
  output logic                      out_valid,
  output logic [DATA_BITS-1:0]      out_data,
  output logic [TIME_BITS-1:0]      out_duration,
  output logic [$clog2(DEPTH):0]    out_count,
  output logic                      out_full,
  output logic                      out_overflow
);

  localparam int unsigned DIV = MAIN_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH) + 1;

  localparam logic [PW-1:0]        PRE_LAST = PW'(DIV - 1);
  localparam logic [TIME_BITS-1:0] DUR_MAX  = '1;
  localparam logic [CW-1:0]        CNT_FULL = CW'(DEPTH);

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [TIME_BITS-1:0] dur;
  } entry_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] cur_q, cur_d;
  logic [TIME_BITS-1:0] dur_q, dur_d;
  logic [PW-1:0]        pre_q, pre_d;

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;

  entry_t               mem_q [DEPTH];

  logic                 tick;
  logic                 push;
  entry_t               push_entry;
  logic                 pop;
  logic                 do_write;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign tick       = (state_q == ST_RUN) && (pre_q == PRE_LAST);
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);

  // State, current-segment and FIFO bookkeeping registers
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      dur_q    <= '0;
      pre_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      dur_q    <= dur_d;
      pre_q    <= pre_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge in_clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Recorder FSM: segment tracking, prescaler, duration and push generation
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    dur_d      = dur_q;
    pre_d      = pre_q;
    push       = 1'b0;
    push_entry = '0;

    case (state_q)
      ST_IDLE: begin
        pre_d = '0;
        dur_d = '0;
        if (in_enable) begin
          cur_d   = in_data;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (!in_enable) begin
          // Flush the open segment; a coincident data change is ignored
          push       = 1'b1;
          push_entry = '{data: cur_q, dur: dur_q};
          pre_d      = '0;
          dur_d      = '0;
          state_d    = ST_IDLE;
        end else if (in_data != cur_q) begin
          push       = 1'b1;
          push_entry = '{data: cur_q, dur: dur_q};
          cur_d      = in_data;
          dur_d      = '0;
          pre_d      = '0;
        end else if (tick && (dur_q == DUR_MAX)) begin
          // Duration saturated: emit and keep recording the same value
          push       = 1'b1;
          push_entry = '{data: cur_q, dur: DUR_MAX};
          dur_d      = '0;
        end else if (tick) begin
          dur_d = dur_q + TIME_BITS'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO control: pop ignored when empty, push dropped when full without pop
  always_comb begin
    pop      = in_read && !fifo_empty;
    do_write = push && (!fifo_full || pop);
    wr_ptr_d = do_write ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_write) - CW'(pop);
    ovf_d    = ovf_q || (push && fifo_full && !pop);
  end

  // Head entry falls through to the outputs; zeroed while empty
  always_comb begin
    out_valid    = !fifo_empty;
    out_data     = '0;
    out_duration = '0;
    if (!fifo_empty) begin
      out_data     = mem_q[rd_ptr_q].data;
      out_duration = mem_q[rd_ptr_q].dur;
    end
  end

  assign out_count    = count_q;
  assign out_full     = fifo_full;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_timed_seq_rec.sv
// Scoreboard bench for timed_seq_rec: DIV = 10, DEPTH = 16, plus a
// TIME_BITS = 4 instance for duration saturation.
module tb_timed_seq_rec;

  localparam int unsigned MAIN_HZ = 1_000_000;
  localparam int unsigned TICK_HZ = 100_000;
  localparam int unsigned DB      = 8;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [7:0]  d;
    logic [15:0] t;
  } exp_t;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          enable = 1'b0;
  logic [DB-1:0] data   = '0;
  logic          rd     = 1'b0;
  logic          rd_s   = 1'b0;

  logic          valid, full, ovf;
  logic [DB-1:0] odata;
  logic [15:0]   odur;
  logic [CW-1:0] count;

  logic          valid_s, full_s, ovf_s;
  logic [DB-1:0] odata_s;
  logic [3:0]    odur_s;
  logic [CW-1:0] count_s;

  exp_t        sb_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  timed_seq_rec #(
    .MAIN_HZ(MAIN_HZ), .TICK_HZ(TICK_HZ), .DATA_BITS(DB), .TIME_BITS(16), .DEPTH(DEPTH)
  ) u_dut (
    .in_clk(clk), .in_rst(rst), .in_enable(enable), .in_data(data), .in_read(rd),
    .out_valid(valid), .out_data(odata), .out_duration(odur), .out_count(count),
    .out_full(full), .out_overflow(ovf)
  );

  timed_seq_rec #(
    .MAIN_HZ(MAIN_HZ), .TICK_HZ(TICK_HZ), .DATA_BITS(DB), .TIME_BITS(4), .DEPTH(DEPTH)
  ) u_sat (
    .in_clk(clk), .in_rst(rst), .in_enable(enable), .in_data(data), .in_read(rd_s),
    .out_valid(valid_s), .out_data(odata_s), .out_duration(odur_s), .out_count(count_s),
    .out_full(full_s), .out_overflow(ovf_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare the main instance head with the oldest expected entry, then pop it
  task automatic pop_and_check(input string tag);
    exp_t e;
    check({tag, "_sb"}, 32'(sb_q.size() != 0), 32'd1);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_data"}, 32'(odata), 32'(e.d));
    check({tag, "_dur"}, 32'(odur), 32'(e.t));
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      if (!valid) break;
      pop_and_check($sformatf("%s%0d", tag, i));
    end
    check({tag, "_left"}, 32'(sb_q.size()), 32'd0);
    check({tag, "_empty"}, 32'(valid), 32'd0);
  endtask

  initial begin
    // Reset with the bus toggling
    rst = 1'b1; enable = 1'b1; data = 8'h55;
    step();
    data = 8'hAA;
    step();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(odata), 32'd0);
    check("rst_dur", 32'(odur), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_full_s", 32'(full_s), 32'd0);
    check("rst_ovf_s", 32'(ovf_s), 32'd0);
    enable = 1'b0; data = 8'h00;
    rst = 1'b0;
    step();

    // Basic capture: change 35 clocks after enable -> (0x00, 3); read while empty ignored
    enable = 1'b1;
    repeat (35) step();
    data = 8'hA5; rd = 1'b1;
    sb_q.push_back('{d: 8'h00, t: 16'd3});
    step();
    rd = 1'b0;
    check("basic_count", 32'(count), 32'd1);
    pop_and_check("basic_head");
    check("basic_popped", 32'(valid), 32'd0);
    enable = 1'b0;
    sb_q.push_back('{d: 8'hA5, t: 16'd0});
    step();
    drain("basic_flush");

    // Overflow: 17 one-cycle segments with no reads
    rst = 1'b1; step(); rst = 1'b0;
    data = 8'h00; enable = 1'b1;
    step();
    for (int i = 1; i <= 17; i++) begin
      data = 8'(i);
      if (i <= 16) sb_q.push_back('{d: 8'(i - 1), t: 16'd0});
      step();
      if (i == 15) check("ovf_full15", 32'(full), 32'd0);
      if (i == 16) check("ovf_full16", 32'(full), 32'd1);
      if (i == 16) check("ovf_clean16", 32'(ovf), 32'd0);
    end
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_head", 32'(odata), 32'd0);

    // Full with simultaneous push and pop
    data = 8'd18; rd = 1'b1;
    void'(sb_q.pop_front());
    sb_q.push_back('{d: 8'd17, t: 16'd0});
    step();
    rd = 1'b0;
    check("pp_count", 32'(count), 32'd16);
    check("pp_full", 32'(full), 32'd1);
    check("pp_ovf", 32'(ovf), 32'd1);
    check("pp_head", 32'(odata), 32'd1);
    enable = 1'b0;
    step();
    check("pp_drop_count", 32'(count), 32'd16);
    drain("pp_drain");

    // Flush on disable 25 clocks after a change to 0x11 -> (0x11, 2)
    data = 8'h00; enable = 1'b1;
    step();
    data = 8'h11;
    sb_q.push_back('{d: 8'h00, t: 16'd0});
    step();
    repeat (24) step();
    enable = 1'b0;
    sb_q.push_back('{d: 8'h11, t: 16'd2});
    step();
    check("flush_count", 32'(count), 32'd2);
    drain("flush");

    // Mid-segment reset clears entries and the sticky overflow
    enable = 1'b1;
    repeat (7) step();
    data = 8'h22;
    step();
    check("mid_pre_ovf", 32'(ovf), 32'd1);
    check("mid_pre_count", 32'(count), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; enable = 1'b0;
    check("mid_count", 32'(count), 32'd0);
    check("mid_ovf", 32'(ovf), 32'd0);
    check("mid_valid", 32'(valid), 32'd0);
    check("mid_data", 32'(odata), 32'd0);
    sb_q.delete();
    step();

    // Saturation on the TIME_BITS = 4 instance
    rst = 1'b1; step(); rst = 1'b0;
    data = 8'h3C; enable = 1'b1;
    step();
    repeat (159) step();
    check("sat_pre_count", 32'(count_s), 32'd0);
    sb_q.push_back('{d: 8'h3C, t: 16'd15});
    step();
    begin
      exp_t e;
      check("sat_count", 32'(count_s), 32'd1);
      check("sat_valid", 32'(valid_s), 32'd1);
      e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
      check("sat_data", 32'(odata_s), 32'(e.d));
      check("sat_dur", 32'(odur_s), 32'(e.t));
      rd_s = 1'b1;
      step();
      rd_s = 1'b0;
      check("sat_popped", 32'(count_s), 32'd0);
      repeat (13) step();
      data = 8'h55;
      sb_q.push_back('{d: 8'h3C, t: 16'd1});
      step();
      e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
      check("sat2_count", 32'(count_s), 32'd1);
      check("sat2_data", 32'(odata_s), 32'(e.d));
      check("sat2_dur", 32'(odur_s), 32'(e.t));
    end
    enable = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
